// File: rtl/mem_probe_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_probe_display: button-stepped memory probe with 7-seg hex/dec view.  |
// | Optional auto-repeat: define MEM_PROBE_AUTO_REPEAT_EN.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_probe_display #(
    parameter int DIGITS        = 4,
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 10,
    parameter int DEBOUNCE      = 4,
    parameter int SCAN_DIV      = 1024,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_inc_i,
    input  logic              btn_dec_i,
    input  logic              show_ptr_i,
    input  logic              hex_mode_i,
    input  logic              upper_half_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DIGITS-1:0] anode_o,
    output logic [7:0]        cathode_o,
    output logic              conv_busy_o
);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int NIB   = (DATA_W + 2) / 3;
    localparam int BC_W  = $clog2(DATA_W);
    localparam int SC_W  = $clog2(SCAN_DIV + 1);
    localparam int IDX_W = $clog2(DIGITS);

    logic [1:0] w_raw;
    logic [1:0] w_step;
    assign w_raw = {btn_dec_i, btn_inc_i};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic            sync1_q, sync2_q, level_q, step_q;
        logic [DB_W-1:0] db_cnt_q;
        logic            w_flip;
        logic            w_rep;

        assign w_flip = (sync2_q != level_q) && (db_cnt_q == DB_W'(DEBOUNCE - 1));

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q  <= 1'b0;
                sync2_q  <= 1'b0;
                level_q  <= 1'b0;
                step_q   <= 1'b0;
                db_cnt_q <= '0;
            end else begin
                sync1_q <= w_raw[b];
                sync2_q <= sync1_q;
                step_q  <= w_flip && !level_q;
                if (w_flip)
                    level_q <= ~level_q;
                if (sync2_q == level_q || w_flip)
                    db_cnt_q <= '0;
                else
                    db_cnt_q <= db_cnt_q + 1'b1;
            end
        end

`ifdef MEM_PROBE_AUTO_REPEAT_EN
        localparam int RD_W = $clog2(REPEAT_DELAY + 1);
        localparam int RP_W = $clog2(REPEAT_PERIOD + 1);
        logic [RD_W-1:0] hold_cnt_q;
        logic [RP_W-1:0] per_cnt_q;
        logic            armed_q;

        // Arm after REPEAT_DELAY held cycles, then fire once per full period.
        always_ff @(posedge clk) begin
            if (reset || !level_q) begin
                hold_cnt_q <= '0;
                per_cnt_q  <= '0;
                armed_q    <= 1'b0;
            end else if (!armed_q) begin
                if (hold_cnt_q == RD_W'(REPEAT_DELAY - 1))
                    armed_q <= 1'b1;
                else
                    hold_cnt_q <= hold_cnt_q + 1'b1;
            end else if (per_cnt_q == RP_W'(REPEAT_PERIOD - 1)) begin
                per_cnt_q <= '0;
            end else begin
                per_cnt_q <= per_cnt_q + 1'b1;
            end
        end
        assign w_rep = armed_q && level_q && (per_cnt_q == RP_W'(REPEAT_PERIOD - 1));
`else
        assign w_rep = 1'b0;
`endif
        assign w_step[b] = step_q | w_rep;
    end

    logic [ADDR_W-1:0] addr_q;
    always_ff @(posedge clk) begin
        if (reset)
            addr_q <= '0;
        else if (w_step[0] && !w_step[1])
            addr_q <= addr_q + 1'b1;
        else if (w_step[1] && !w_step[0])
            addr_q <= addr_q - 1'b1;
    end
    assign mem_addr_o = addr_q;

    logic [DATA_W-1:0] w_src;
    always_comb begin
        w_src                 = '0;
        w_src[ADDR_W-1:0]     = addr_q;
        if (!show_ptr_i)
            w_src = mem_data_i;
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t              state_q;
    logic                snap_valid_q, snap_hex_q, snap_upper_q;
    logic [DATA_W-1:0]   snap_src_q, shift_q;
    logic [4*NIB-1:0]    bcd_q, w_bcd_adj;
    logic [BC_W-1:0]     bit_cnt_q;
    logic [4*DIGITS-1:0] digit_q, w_win, w_digits;
    logic                dash_q, dp_q;
    logic                w_ovf, w_changed;

    always_comb begin
        w_bcd_adj = bcd_q;
        for (int n = 0; n < NIB; n++)
            if (bcd_q[4*n +: 4] >= 4'd5)
                w_bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
    end

    always_comb begin
        w_win    = snap_upper_q ? snap_src_q[DATA_W-1 -: 4*DIGITS] : snap_src_q[4*DIGITS-1:0];
        w_digits = snap_hex_q ? w_win : bcd_q[4*DIGITS-1:0];
    end

    assign w_ovf     = |bcd_q[4*NIB-1:4*DIGITS];
    assign w_changed = !snap_valid_q || (w_src != snap_src_q) ||
                       (hex_mode_i != snap_hex_q) || (upper_half_i != snap_upper_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            snap_valid_q <= 1'b0;
            snap_hex_q   <= 1'b0;
            snap_upper_q <= 1'b0;
            snap_src_q   <= '0;
            shift_q      <= '0;
            bcd_q        <= '0;
            bit_cnt_q    <= '0;
            digit_q      <= '0;
            dash_q       <= 1'b0;
            dp_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_changed) begin
                        snap_valid_q <= 1'b1;
                        snap_src_q   <= w_src;
                        snap_hex_q   <= hex_mode_i;
                        snap_upper_q <= upper_half_i;
                        shift_q      <= w_src;
                        bcd_q        <= '0;
                        bit_cnt_q    <= '0;
                        state_q      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_q   <= {w_bcd_adj[4*NIB-2:0], shift_q[DATA_W-1]};
                    shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
                        bit_cnt_q <= '0;
                        state_q   <= S_COMMIT;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                S_COMMIT: begin
                    digit_q <= w_digits;
                    dash_q  <= !snap_hex_q && w_ovf;
                    dp_q    <= snap_hex_q && snap_upper_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
    assign conv_busy_o = (state_q != S_IDLE);

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 8'hC0;  4'h1: seg_code = 8'hF9;
            4'h2: seg_code = 8'hA4;  4'h3: seg_code = 8'hB0;
            4'h4: seg_code = 8'h99;  4'h5: seg_code = 8'h92;
            4'h6: seg_code = 8'h82;  4'h7: seg_code = 8'hF8;
            4'h8: seg_code = 8'h80;  4'h9: seg_code = 8'h90;
            4'hA: seg_code = 8'h88;  4'hB: seg_code = 8'h83;
            4'hC: seg_code = 8'hC6;  4'hD: seg_code = 8'hA1;
            4'hE: seg_code = 8'h86;  default: seg_code = 8'h8E;
        endcase
    endfunction

    logic [SC_W-1:0]   scan_cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DIGITS-1:0] anode_q;
    logic [7:0]        cathode_q, w_seg;

    always_comb begin
        w_seg = dash_q ? 8'hBF : seg_code(digit_q[idx_q*4 +: 4]);
        if (!dash_q && dp_q && (idx_q == IDX_W'(DIGITS - 1)))
            w_seg[7] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            anode_q    <= '1;
            cathode_q  <= 8'hFF;
        end else begin
            anode_q   <= ~(DIGITS'(1) << idx_q);
            cathode_q <= w_seg;
            if (scan_cnt_q == SC_W'(SCAN_DIV - 1)) begin
                scan_cnt_q <= '0;
                idx_q      <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                scan_cnt_q <= scan_cnt_q + 1'b1;
            end
        end
    end
    assign anode_o   = anode_q;
    assign cathode_o = cathode_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_probe_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_probe_display: directed self-checking bench for mem_probe_display |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_probe_display;
    localparam int DIGITS        = 4;
    localparam int DATA_W        = 32;
    localparam int ADDR_W        = 10;
    localparam int DEBOUNCE      = 4;
    localparam int SCAN_DIV      = 8;
    localparam int REPEAT_DELAY  = 40;
    localparam int REPEAT_PERIOD = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              btn_inc = 1'b0, btn_dec = 1'b0;
    logic              show_ptr = 1'b1, hex_mode = 1'b1, upper_half = 1'b0;
    logic [DATA_W-1:0] mem_data = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DIGITS-1:0] anode;
    logic [7:0]        cathode;
    logic              conv_busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] got [DIGITS];

    mem_probe_display #(
        .DIGITS(DIGITS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEBOUNCE(DEBOUNCE),
        .SCAN_DIV(SCAN_DIV), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) dut (
        .clk(clk), .reset(reset), .btn_inc_i(btn_inc), .btn_dec_i(btn_dec),
        .show_ptr_i(show_ptr), .hex_mode_i(hex_mode), .upper_half_i(upper_half),
        .mem_data_i(mem_data), .mem_addr_o(mem_addr), .anode_o(anode),
        .cathode_o(cathode), .conv_busy_o(conv_busy)
    );

    always #5 clk = ~clk;

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Capture one full scan; digits never seen stay at 8'h00.
    task automatic read_display();
        for (int i = 0; i < DIGITS; i++) got[i] = 8'h00;
        for (int k = 0; k < DIGITS*SCAN_DIV + 4; k++) begin
            @(negedge clk);
            for (int i = 0; i < DIGITS; i++)
                if (anode == ~(DIGITS'(1) << i)) got[i] = cathode;
        end
    endtask

    task automatic press(input logic inc, input logic dec, input int hold);
        @(negedge clk);
        btn_inc = inc;
        btn_dec = dec;
        wait_cycles(hold);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        wait_cycles(15);
    endtask

    task automatic test_reset();
        logic [DIGITS-1:0] exp_an;
        show_ptr = 1'b1; hex_mode = 1'b1; upper_half = 1'b0;
        reset = 1'b1;
        wait_cycles(3);
        checks++;
        if (anode !== 4'hF || cathode !== 8'hFF) begin
            errors++;
            $display("FAIL reset_blank: anode=%b cathode=%h required 1111/ff", anode, cathode);
        end
        checks++;
        if (mem_addr !== 10'd0 || conv_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: mem_addr=%0d conv_busy=%b required 0/0", mem_addr, conv_busy);
        end
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            exp_an = ~(DIGITS'(1) << (((k - 1) / SCAN_DIV) % DIGITS));
            checks++;
            if (anode !== exp_an) begin
                errors++;
                $display("FAIL anode_seq[%0d]: got %b required %b", k, anode, exp_an);
            end
            if (k == 1) begin
                checks++;
                if (cathode !== 8'hC0) begin
                    errors++;
                    $display("FAIL first_cathode: got %h required c0", cathode);
                end
            end
        end
        read_display();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== 8'hC0) begin
                errors++;
                $display("FAIL reset_digit%0d: got %h required c0", i, got[i]);
            end
        end
    endtask

    task automatic test_debounce();
        press(1'b1, 1'b0, 2);
        checks++;
        if (mem_addr !== 10'd0) begin
            errors++;
            $display("FAIL glitch_ignored: mem_addr=%0d required 0", mem_addr);
        end
        @(negedge clk);
        btn_inc = 1'b1;
        for (int k = 1; k <= DEBOUNCE + 3; k++) begin
            @(negedge clk);
            if (k == DEBOUNCE + 2) begin
                checks++;
                if (mem_addr !== 10'd0) begin
                    errors++;
                    $display("FAIL step_early: mem_addr=%0d required 0 at edge %0d", mem_addr, k);
                end
            end
        end
        checks++;
        if (mem_addr !== 10'd1) begin
            errors++;
            $display("FAIL step_latency: mem_addr=%0d required 1 at edge %0d", mem_addr, DEBOUNCE + 3);
        end
        wait_cycles(20 - (DEBOUNCE + 3));
        btn_inc = 1'b0;
        wait_cycles(15);
        checks++;
        if (mem_addr !== 10'd1) begin
            errors++;
            $display("FAIL single_step: mem_addr=%0d required 1", mem_addr);
        end
    endtask

    task automatic test_dec_decimal();
        show_ptr = 1'b1; hex_mode = 1'b0; upper_half = 1'b0;
        press(1'b0, 1'b1, 20);
        checks++;
        if (mem_addr !== 10'd0) begin
            errors++;
            $display("FAIL dec_to_zero: mem_addr=%0d required 0", mem_addr);
        end
        press(1'b0, 1'b1, 20);
        checks++;
        if (mem_addr !== 10'd1023) begin
            errors++;
            $display("FAIL dec_wrap: mem_addr=%0d required 1023", mem_addr);
        end
        wait_cycles(40);
        read_display();
        checks++;
        if (got[3] !== 8'hF9 || got[2] !== 8'hC0 || got[1] !== 8'hA4 || got[0] !== 8'hB0) begin
            errors++;
            $display("FAIL dec_1023: got %h %h %h %h required f9 c0 a4 b0", got[3], got[2], got[1], got[0]);
        end
        press(1'b1, 1'b1, 20);
        checks++;
        if (mem_addr !== 10'd1023) begin
            errors++;
            $display("FAIL simultaneous: mem_addr=%0d required 1023", mem_addr);
        end
    endtask

    task automatic test_hex_window();
        show_ptr = 1'b0; hex_mode = 1'b1; upper_half = 1'b0;
        mem_data = 32'h1234ABCD;
        wait_cycles(40);
        read_display();
        checks++;
        if (got[3] !== 8'h88 || got[2] !== 8'h83 || got[1] !== 8'hC6 || got[0] !== 8'hA1) begin
            errors++;
            $display("FAIL hex_lower: got %h %h %h %h required 88 83 c6 a1", got[3], got[2], got[1], got[0]);
        end
        upper_half = 1'b1;
        wait_cycles(40);
        read_display();
        checks++;
        if (got[3] !== 8'h79 || got[2] !== 8'hA4 || got[1] !== 8'hB0 || got[0] !== 8'h99) begin
            errors++;
            $display("FAIL hex_upper_dp: got %h %h %h %h required 79 a4 b0 99", got[3], got[2], got[1], got[0]);
        end
    endtask

    task automatic test_decimal_overflow();
        int busy_cycles;
        show_ptr = 1'b0; hex_mode = 1'b0; upper_half = 1'b0;
        mem_data = 32'd9999;
        wait_cycles(40);
        read_display();
        checks++;
        if (got[3] !== 8'h90 || got[2] !== 8'h90 || got[1] !== 8'h90 || got[0] !== 8'h90) begin
            errors++;
            $display("FAIL dec_9999: got %h %h %h %h required 90 90 90 90", got[3], got[2], got[1], got[0]);
        end
        mem_data = 32'd12345;
        busy_cycles = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (conv_busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != DATA_W + 1) begin
            errors++;
            $display("FAIL busy_len: got %0d cycles required %0d", busy_cycles, DATA_W + 1);
        end
        read_display();
        for (int i = 0; i < DIGITS; i++) begin
            checks++;
            if (got[i] !== 8'hBF) begin
                errors++;
                $display("FAIL overflow_digit%0d: got %h required bf", i, got[i]);
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        mem_data = 32'd5;
        wait_cycles(6);
        checks++;
        if (conv_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_shift: got %b required 1", conv_busy);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (conv_busy !== 1'b0 || anode !== 4'hF || cathode !== 8'hFF || mem_addr !== 10'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b anode=%b cathode=%h addr=%0d required 0/1111/ff/0",
                     conv_busy, anode, cathode, mem_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (anode !== 4'b1110 || cathode !== 8'hC0) begin
            errors++;
            $display("FAIL digits_cleared: anode=%b cathode=%h required 1110/c0", anode, cathode);
        end
    endtask

    task automatic test_auto_repeat();
        logic [ADDR_W-1:0] exp_addr;
`ifdef MEM_PROBE_AUTO_REPEAT_EN
        exp_addr = 10'd4;
`else
        exp_addr = 10'd1;
`endif
        press(1'b1, 1'b0, REPEAT_DELAY + 3*REPEAT_PERIOD + 10);
        checks++;
        if (mem_addr !== exp_addr) begin
            errors++;
            $display("FAIL long_hold: mem_addr=%0d required %0d", mem_addr, exp_addr);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_dec_decimal();
        test_hex_window();
        test_decimal_overflow();
        test_reset_mid_shift();
        test_auto_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
